// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the AVR window and a DMA port.
// Latency: grant in IDLE; read ack 3 cycles after grant, write ack 2 cycles after grant.
// Backpressure: AVR is stalled via combinational avr_wait; DMA holds dma_req until the dma_ack pulse.
module sram_arbiter #(
  parameter logic [15:0] SRAM_BASE  = 16'hE000,
  parameter int          ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [15:0]           avr_a,
  input  logic [7:0]            avr_d_out,
  input  logic                  avr_cs,
  input  logic                  avr_oe,
  input  logic                  avr_we,
  output logic [7:0]            avr_d_in,
  output logic                  avr_wait,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [7:0]            dma_wdata,
  output logic                  dma_ack,
  output logic [7:0]            dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  localparam logic OWN_AVR = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   op_we;

  logic                  a_req;
  logic                  d_req;
  logic                  grant_dma;
  logic                  next_we;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            next_wdata;
  logic [15:0]           avr_off;
  logic                  avr_off_unused;

  // Request decode; the window offset wraps modulo the window size, so upper offset bits are dropped.
  assign a_req          = avr_cs & (avr_oe | avr_we);
  assign d_req          = dma_req;
  assign avr_off        = avr_a - SRAM_BASE;
  assign avr_off_unused = ^avr_off[15:ADDR_WIDTH];

  // Round-robin: a lone requester wins; on conflict the port not served last wins.
  assign grant_dma  = d_req & (~a_req | (last_grant == OWN_AVR));
  assign next_we    = grant_dma ? dma_we    : avr_we;
  assign next_addr  = grant_dma ? dma_addr  : avr_off[ADDR_WIDTH-1:0];
  assign next_wdata = grant_dma ? dma_wdata : avr_d_out;

  // AVR stall is combinational so it is already high in the cycle the request first appears.
  assign avr_wait = a_req & ~((state == ACK) & (owner == OWN_AVR));

  // Access sequencer: IDLE -> ISSUE -> (CAPTURE for reads) -> ACK -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      owner      <= OWN_AVR;
      last_grant <= OWN_DMA;
      op_we      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dma_ack    <= 1'b0;
      dma_rdata  <= '0;
      avr_d_in   <= '0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | d_req) begin
            owner     <= grant_dma;
            op_we     <= next_we;
            mem_addr  <= next_addr;
            mem_wdata <= next_wdata;
            mem_en    <= 1'b1;
            mem_we    <= next_we;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (op_we) begin
            dma_ack <= (owner == OWN_DMA);
            state   <= ACK;
          end else begin
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (owner == OWN_DMA) begin
            dma_rdata <= mem_rdata;
            dma_ack   <= 1'b1;
          end else begin
            avr_d_in  <= mem_rdata;
          end
          state <= ACK;
        end
        ACK: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
